// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, FSM encoding, round constants and FIPS 180-4 helper functions.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [7:0]  hstate_t;   // index 0 = a / H0
    typedef word_t [15:0] wblock_t;   // index 0 = W0

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hstate_t IV = '{
        0: 32'h6a09e667, 1: 32'hbb67ae85, 2: 32'h3c6ef372, 3: 32'ha54ff53a,
        4: 32'h510e527f, 5: 32'h9b05688c, 6: 32'h1f83d9ab, 7: 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 round: a..h, Wt, Kt in, next a..h out.
module sha256_round_step
    import sha256_pkg::*;
(
    input  hstate_t st_i,
    input  word_t   w_i,
    input  word_t   k_i,
    output hstate_t st_o
);

    word_t t1;
    word_t t2;

    assign t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    assign t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

    assign st_o[0] = t1 + t2;
    assign st_o[1] = st_i[0];
    assign st_o[2] = st_i[1];
    assign st_o[3] = st_i[2];
    assign st_o[4] = st_i[3] + t1;
    assign st_o[5] = st_i[4];
    assign st_o[6] = st_i[5];
    assign st_o[7] = st_i[6];

endmodule

// File: rtl/sha256_block_engine.sv
// Multi-block SHA-256 compression engine with UNROLL rounds per clock.
// Optional SHA256D_EN: rehash the final digest from the IV (double SHA-256) before OUT.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_block_valid,
    output logic              o_block_ready,
    input  logic [15:0][31:0] i_block,
    input  logic              i_first,
    input  logic              i_last,
    output logic [7:0][31:0]  o_digest,
    output logic              o_digest_valid,
    input  logic              i_digest_ready,
    output logic              o_busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha256_block_engine: UNROLL must be 1, 2 or 4");
    end

    state_t     state_q, state_d;
    wblock_t    w_q, w_d, ring;
    hstate_t    chain_q, chain_d, work_q, work_d;
    logic [5:0] cnt_q, cnt_d;
    logic       first_q, first_d, last_q, last_d;
`ifdef SHA256D_EN
    logic       second_q, second_d;
`endif

    word_t   wt [UNROLL];
    word_t   kt [UNROLL];
    hstate_t st [UNROLL+1];

    // Rolling schedule: word t overwrites slot t mod 16, which held w[t-16].
    always_comb begin
        logic [5:0] t;
        logic [3:0] idx;
        ring = w_q;
        t    = cnt_q;
        idx  = t[3:0];
        for (int u = 0; u < UNROLL; u++) begin
            t   = cnt_q + 6'(u);
            idx = t[3:0];
            // NOTE: blocking assignments are deliberate here: a later unrolled word reads the ring slots written earlier in this same pass.
            if (t >= 6'd16) begin
                ring[idx] = small_sigma1(ring[idx - 4'd2]) + ring[idx - 4'd7]
                          + small_sigma0(ring[idx - 4'd15]) + ring[idx];
            end
            wt[u] = ring[idx];
            kt[u] = K[t];
        end
    end

    assign st[0] = work_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        sha256_round_step u_step (
            .st_i (st[g]),
            .w_i  (wt[g]),
            .k_i  (kt[g]),
            .st_o (st[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            // NOTE: the 16-word schedule is a plain register bank and is reset with everything else; it is not meant to map to RAM.
            w_q      <= '0;
            chain_q  <= IV;
            work_q   <= IV;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef SHA256D_EN
            second_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the values present before the edge.
            state_q  <= state_d;
            w_q      <= w_d;
            chain_q  <= chain_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
`ifdef SHA256D_EN
            second_q <= second_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets a hold default first, so no branch can infer a latch.
        state_d  = state_q;
        w_d      = w_q;
        chain_d  = chain_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        last_d   = last_q;
`ifdef SHA256D_EN
        second_d = second_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_block_valid) begin
                    w_d     = i_block;
                    first_d = i_first;
                    last_d  = i_last;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (first_q) begin
                    chain_d = IV;
                    work_d  = IV;
                end else begin
                    work_d  = chain_q;
                end
                cnt_d   = '0;
                state_d = ROUND;
            end
            ROUND: begin
                work_d = st[UNROLL];
                w_d    = ring;
                cnt_d  = cnt_q + 6'(UNROLL);
                if (cnt_q == 6'(64 - UNROLL)) state_d = FINAL;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) chain_d[i] = chain_q[i] + work_q[i];
                if (!last_q) begin
                    state_d = IDLE;
                end else begin
`ifdef SHA256D_EN
                    if (!second_q) begin
                        // Second pass: padded 256-bit digest as a single block, hashed from the IV.
                        w_d[7:0]  = chain_d;
                        w_d[8]    = 32'h8000_0000;
                        w_d[14:9] = '0;
                        w_d[15]   = 32'h0000_0100;
                        first_d   = 1'b1;
                        second_d  = 1'b1;
                        state_d   = LOAD;
                    end else begin
                        second_d  = 1'b0;
                        state_d   = OUT;
                    end
`else
                    state_d = OUT;
`endif
                end
            end
            OUT: begin
                if (i_digest_ready || !OUT_HOLD) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_block_ready  = rst_n && (state_q == IDLE);
        o_busy         = (state_q != IDLE);
        o_digest_valid = (state_q == OUT);
        o_digest       = (state_q == OUT) ? chain_q : '0;
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Self-checking bench: three engines (UNROLL 1/2/4) against a word-array SHA-256 reference model.
module tb_sha256_block_engine;

    typedef logic [7:0][31:0]  h_t;
    typedef logic [15:0][31:0] b_t;
    localparam int ND = 3;

    localparam logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVW [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] M448 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071};

    logic clk = 1'b0;
    logic rst_n;
    logic bv [ND], br [ND], first [ND], last [ND], drdy [ND], dv [ND], busy [ND];
    b_t   blk [ND];
    h_t   dig [ND];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    b_t q_abc [$];
    b_t q448 [$];
    h_t h_abc, h448;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sha256_block_engine #(.UNROLL(1 << g), .OUT_HOLD(1'b1)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_block_valid  (bv[g]),
            .o_block_ready  (br[g]),
            .i_block        (blk[g]),
            .i_first        (first[g]),
            .i_last         (last[g]),
            .o_digest       (dig[g]),
            .o_digest_valid (dv[g]),
            .i_digest_ready (drdy[g]),
            .o_busy         (busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic h_t compress(input h_t hin, input b_t b);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        h_t r;
        for (int t = 0; t < 16; t++) w[t] = b[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KM[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
        return r;
    endfunction

    function automatic h_t iv_h();
        h_t r;
        for (int i = 0; i < 8; i++) r[i] = IVW[i];
        return r;
    endfunction

    function automatic h_t finish_hash(input h_t h);
`ifdef SHA256D_EN
        b_t b = '0;
        for (int i = 0; i < 8; i++) b[i] = h[i];
        b[8]  = 32'h80000000;
        b[15] = 32'h00000100;
        return compress(iv_h(), b);
`else
        return h;
`endif
    endfunction

    function automatic h_t hash_msg(input b_t m [$]);
        h_t r = iv_h();
        foreach (m[i]) r = compress(r, m[i]);
        return finish_hash(r);
    endfunction

    function automatic h_t mk_h(input logic [255:0] be);
        h_t r;
        for (int i = 0; i < 8; i++) r[i] = be[255 - 32*i -: 32];
        return r;
    endfunction

    // cycle number (LOAD = 1) in which o_digest_valid is first seen
    function automatic int exp_lat(input int k);
        int pass = 2 + 64 / (1 << k);
`ifdef SHA256D_EN
        return 2 * pass + 1;
`else
        return pass + 1;
`endif
    endfunction

    // ---------------- checking and handshake tasks ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of the LOAD cycle
    task automatic xfer(input int k, output int t_acc);
        int n = 0;
        bv[k] = 1'b1;
        while (br[k] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (br[k] !== 1'b1) begin
            check($sformatf("accept_timeout_u%0d", 1 << k), 0, 1);
            bv[k] = 1'b0;
            t_acc = -1;
            return;
        end
        @(negedge clk);
        t_acc = cyc;
        bv[k] = 1'b0;
    endtask

    task automatic get_digest(input int k, input int t_acc, output h_t d, output int lat);
        int n = 0;
        while (dv[k] !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        if (dv[k] !== 1'b1) begin
            check($sformatf("digest_timeout_u%0d", 1 << k), 0, 1);
            d = '0;
            lat = -1;
            return;
        end
        d   = dig[k];
        lat = cyc - t_acc + 1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int k, input string tag);
        int n = 0;
        int saw = 0;
        while (busy[k] === 1'b1 && n < 800) begin
            if (dv[k] === 1'b1) saw = 1;
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_u%0d_novalid", tag, 1 << k), saw, 0);
        check($sformatf("%s_u%0d_idle", tag, 1 << k), busy[k], 0);
    endtask

    task automatic run_msg(input int k, input b_t m [$], input h_t exp, input string tag);
        int t, lat;
        h_t d;
        t = -1;
        foreach (m[i]) begin
            blk[k]   = m[i];
            first[k] = (i == 0);
            last[k]  = (i == m.size() - 1);
            xfer(k, t);
            if (i < m.size() - 1) wait_idle(k, tag);
        end
        get_digest(k, t, d, lat);
        check($sformatf("%s_u%0d_digest", tag, 1 << k), d, exp);
        check($sformatf("%s_u%0d_latency", tag, 1 << k), lat, exp_lat(k));
    endtask

    task automatic backpressure(input int k);
        int t, lat, t_rel;
        int hold_bad = 0;
        int rdy_seen = 0;
        h_t d, d0;
        drdy[k]  = 1'b0;
        blk[k]   = q_abc[0];
        first[k] = 1'b1;
        last[k]  = 1'b1;
        xfer(k, t);
        get_digest(k, t, d, lat);
        check($sformatf("bp_u%0d_digest", 1 << k), d, h_abc);
        d0    = d;
        bv[k] = 1'b1;   // next block offered while the digest is stalled
        repeat (20) begin
            @(negedge clk);
            if (dig[k] !== d0 || dv[k] !== 1'b1) hold_bad++;
            if (br[k] !== 1'b0) rdy_seen++;
        end
        check($sformatf("bp_u%0d_hold", 1 << k), hold_bad, 0);
        check($sformatf("bp_u%0d_ready_low", 1 << k), rdy_seen, 0);
        drdy[k] = 1'b1;
        t_rel   = cyc;
        xfer(k, t);
        check($sformatf("bp_u%0d_accept_after", 1 << k), t - t_rel, 2);
        get_digest(k, t, d, lat);
        check($sformatf("bp_u%0d_digest2", 1 << k), d, h_abc);
    endtask

    task automatic busy_offer(input int k);
        int t1, t2, lat;
        h_t d;
        blk[k]   = q448[0];
        first[k] = 1'b1;
        last[k]  = 1'b0;
        xfer(k, t1);
        blk[k]   = q_abc[0];
        first[k] = 1'b1;
        last[k]  = 1'b1;
        xfer(k, t2);
        check($sformatf("busy_u%0d_accept_gap", 1 << k), t2 - t1, 3 + 64 / (1 << k));
        get_digest(k, t2, d, lat);
        check($sformatf("restart_u%0d_digest", 1 << k), d, h_abc);
    endtask

    task automatic reset_mid();
        int ta [ND];
        for (int k = 0; k < ND; k++) begin
            blk[k]   = q_abc[0];
            first[k] = 1'b1;
            last[k]  = 1'b1;
        end
        fork
            xfer(0, ta[0]);
            xfer(1, ta[1]);
            xfer(2, ta[2]);
        join
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rstmid_u%0d_ready", 1 << k), br[k], 0);
            check($sformatf("rstmid_u%0d_valid", 1 << k), dv[k], 0);
            check($sformatf("rstmid_u%0d_busy", 1 << k), busy[k], 0);
            check($sformatf("rstmid_u%0d_digest", 1 << k), dig[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fork
            run_msg(0, q_abc, h_abc, "postrst");
            run_msg(1, q_abc, h_abc, "postrst");
            run_msg(2, q_abc, h_abc, "postrst");
        join
    endtask

    task automatic random_msgs(input int k);
        b_t q [$];
        b_t b;
        int nb;
        repeat (3) begin
            q.delete();
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                for (int w = 0; w < 16; w++) b[w] = $urandom;
                q.push_back(b);
            end
            run_msg(k, q, hash_msg(q), "rnd");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        b_t b;
        for (int k = 0; k < ND; k++) begin
            bv[k] = 1'b0; drdy[k] = 1'b1; first[k] = 1'b0; last[k] = 1'b0; blk[k] = '0;
        end
        b = '0; b[0] = 32'h61626380; b[15] = 32'h00000018;
        q_abc.push_back(b);
        b = '0;
        for (int i = 0; i < 14; i++) b[i] = M448[i];
        b[14] = 32'h80000000;
        q448.push_back(b);
        b = '0; b[15] = 32'h000001c0;
        q448.push_back(b);
`ifdef SHA256D_EN
        h_abc = mk_h(256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358);
`else
        h_abc = mk_h(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
`endif
        h448 = finish_hash(mk_h(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1));

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rst_u%0d_ready", 1 << k), br[k], 0);
            check($sformatf("rst_u%0d_valid", 1 << k), dv[k], 0);
            check($sformatf("rst_u%0d_busy", 1 << k), busy[k], 0);
            check($sformatf("rst_u%0d_digest", 1 << k), dig[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) check($sformatf("rst_u%0d_ready_after", 1 << k), br[k], 1);
        @(negedge clk);

        fork
            run_msg(0, q_abc, h_abc, "abc");
            run_msg(1, q_abc, h_abc, "abc");
            run_msg(2, q_abc, h_abc, "abc");
        join
        fork
            run_msg(0, q448, h448, "two");
            run_msg(1, q448, h448, "two");
            run_msg(2, q448, h448, "two");
        join
        fork
            backpressure(0);
            backpressure(1);
            backpressure(2);
        join
        fork
            busy_offer(0);
            busy_offer(1);
            busy_offer(2);
        join
        reset_mid();
        fork
            random_msgs(0);
            random_msgs(1);
            random_msgs(2);
        join

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
- Parametrised SHA-256 compression engine for multi-block messages.
- Accepts 512-bit pre-padded blocks over a valid/ready handshake and keeps the chaining state between blocks.
- Runs the 64 rounds with a configurable unroll factor, using an internal 16-word rolling message schedule.
- Presents the final 256-bit digest on a valid/ready output. Sits between the mining header formatter and the nonce comparator.

Parameters:
UNROLL, 1, rounds per clock; legal values 1, 2, 4 (elaboration error otherwise)
OUT_HOLD, 1, 1: o_digest held until accepted; 0: o_digest_valid is a single-cycle pulse and i_digest_ready is ignored

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, reset asynchronous and active-low
i_block_valid  input  1  block offered
o_block_ready  output  1  engine can accept a block
i_block  input  16x32  message words W0..W15, W0 = first big-endian word
i_first  input  1  block starts a new message; chain loaded with IV
i_last  input  1  block ends the message; digest produced after it
o_digest  output  8x32  H0..H7
o_digest_valid  output  1  digest available
i_digest_ready  input  1  consumer takes digest
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: o_block_ready=0 during reset, 1 in first cycle after; o_digest=0; o_digest_valid=0; o_busy=0. Chain and working registers reset to the IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19. Round counter = 0.
- FSM states and transitions:
  - IDLE: o_block_ready=1. A transfer occurs when i_block_valid && o_block_ready. On transfer, capture i_block, i_first and i_last, then go to LOAD.
  - LOAD (1 cycle): load a..h from the IV if i_first, else from the chain; counter=0.
  - ROUND: each cycle perform UNROLL rounds t..t+UNROLL-1 and counter += UNROLL. Leave ROUND after the cycle that performs round 63.
  - FINAL (1 cycle): chain[i] = chain_or_IV[i] + working[i], mod 2^32. If last, go to OUT; otherwise go to IDLE.
  - OUT: o_digest = chain, o_digest_valid=1. Leave on i_digest_ready (or after 1 cycle if OUT_HOLD=0), then go to IDLE.
- Latency: accept to FINAL complete = 2 + 64/UNROLL cycles. The digest is valid the cycle after FINAL. At UNROLL=1, o_digest_valid rises 67 cycles after the accept edge.
- Message schedule:
  - 16-entry ring buffer. Rounds 0..15 use i_block words directly.
  - For t ≥ 16: w[t mod 16] = σ1(w[t-2]) + w[t-7] + σ0(w[t-15]) + w[t-16]. All adds are mod 2^32.
  - With UNROLL > 1, words t..t+UNROLL-1 are computed combinationally in the same cycle, chained where dependent.
- Round arithmetic follows FIPS 180-4; the K constant comes from a ROM indexed by t.
- o_block_ready stays 0 outside IDLE. i_block_valid asserted while busy is ignored and the upstream must hold it.
- A non-last block produces no output.
- i_first && i_last on the same block is a single-block message.
- i_first on a block while a multi-block message is open discards the old chain.
- Counter is 6 bits; reaching 64 wraps to 0, and the FSM has already left ROUND by then.
- OUT with i_digest_ready=0 holds o_digest stable indefinitely. No new block is accepted until the digest is taken.
- rst_n asserted mid-operation aborts asynchronously. All state returns to reset values; the partial message is lost.

Optional Feature:
SHA256D_EN
- Defined: after FINAL of the last block, the engine automatically hashes the 256-bit digest again from the IV, as one block with H0..H7, 0x80000000, six zero words and length word 0x00000100. That adds 2 + 64/UNROLL cycles.
- Defined: OUT presents the double hash, and o_busy stays high through the second pass.
- Undefined: single SHA-256 only; the extra pass and its mux are not built.

Decomposition:
- Package sha256_pkg: K[0:63] constant array; IV[0:7] constant; word_t (32-bit) typedef; state_t enum {IDLE, LOAD, ROUND, FINAL, OUT}; functions ch, maj, Σ0, Σ1, σ0, σ1.
- Sub-module sha256_round_step: one combinational round taking a..h, Wt and Kt and producing next a..h. Instantiated UNROLL times in a chain.

Test Plan:
- "abc" single block (i_first=i_last=1, 61626380 …, length 00000018), UNROLL=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; valid 67 cycles after accept.
- 448-bit "abcdbcdecdefdefg…nopq" as two blocks (first, then last), UNROLL=2 and 4 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no o_digest_valid after block 1.
- Backpressure: i_digest_ready=0 for 20 cycles in OUT -> o_digest stable, o_block_ready=0; next block accepted only after the handshake.
- Block offered while busy -> ignored until IDLE. Then i_first mid-message restarts the hash: "abc" digest as above.
- rst_n pulsed at round 30 -> all outputs return to reset values immediately. A following "abc" gives the correct digest.
- SHA256D_EN with "abc" -> 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358.
